// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file: byte-enabled write port, registered multi-port reads, clear sequencer
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int READ_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_in,
    input  logic [ADDR_WIDTH-1:0]            write_addr_in,
    input  logic [DATA_WIDTH-1:0]            write_data_in,
    input  logic [DATA_WIDTH/8-1:0]          write_be_in,
    input  logic                             read_in,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr_in,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data_out,
    output logic                             read_valid_out,
    input  logic                             clear_in,
    output logic                             busy_out,
    input  logic                             debugen_in
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_CLEAR = 1'b1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]            clear_ptr_q, clear_ptr_d;
    logic [READ_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                             rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];

    logic                             idle;
    logic                             wr_en;
    logic [DATA_WIDTH-1:0]            wr_mask;
    logic [DATA_WIDTH-1:0]            wr_merged;
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_values;
    logic                             unused_debugen;

    assign unused_debugen = debugen_in;
    assign idle           = (state_q == STATE_IDLE);
    assign wr_en          = idle && write_in && ({1'b0, write_addr_in} < DEPTH_W);
    assign wr_merged      = (mem_q[write_addr_in] & ~wr_mask) | (write_data_in & wr_mask);

    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < NBYTES; k++) begin
            wr_mask[8*k +: 8] = {8{write_be_in[k]}};
        end
    end

    // Write-first: a port reading the address being written sees the merged word.
    always_comb begin
        rd_values = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            logic [ADDR_WIDTH-1:0] ra;
            ra = read_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
            if ({1'b0, ra} < DEPTH_W) begin
                if (wr_en && (write_addr_in == ra)) begin
                    rd_values[p*DATA_WIDTH +: DATA_WIDTH] = wr_merged;
                end else begin
                    rd_values[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        if (state_q == STATE_CLEAR) begin
            clear_ptr_d = clear_ptr_q + 1'b1;
            if (clear_ptr_q == LAST_PTR) begin
                state_d     = STATE_IDLE;
                clear_ptr_d = '0;
            end
        end else begin
            if (clear_in) begin
                state_d = STATE_CLEAR;
            end
            if (read_in) begin
                rvalid_d = 1'b1;
                rdata_d  = rd_values;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= STATE_CLEAR;
            clear_ptr_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state_q == STATE_CLEAR) begin
            mem_q[clear_ptr_q] <= '0;
        end else if (wr_en) begin
            mem_q[write_addr_in] <= wr_merged;
        end
    end

    assign read_data_out  = rdata_q;
    assign read_valid_out = rvalid_q;
    assign busy_out       = (state_q == STATE_CLEAR);
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp (DEPTH 16 and 12 instances)
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RP = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic write_in = 1'b0;
    logic read_in = 1'b0;
    logic clear_in = 1'b0;
    logic debugen_in = 1'b0;
    logic [AW-1:0]    write_addr_in = '0;
    logic [DW-1:0]    write_data_in = '0;
    logic [DW/8-1:0]  write_be_in = '0;
    logic [RP*AW-1:0] read_addr_in = '0;
    logic [RP*DW-1:0] rd_a, rd_b;
    logic             rv_a, rv_b, busy_a, busy_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW), .READ_PORTS(RP)) u_dut16 (
        .clk(clk), .reset(reset), .write_in(write_in), .write_addr_in(write_addr_in),
        .write_data_in(write_data_in), .write_be_in(write_be_in), .read_in(read_in),
        .read_addr_in(read_addr_in), .read_data_out(rd_a), .read_valid_out(rv_a),
        .clear_in(clear_in), .busy_out(busy_a), .debugen_in(debugen_in)
    );

    regfile_mp #(.DATA_WIDTH(DW), .DEPTH(12), .ADDR_WIDTH(AW), .READ_PORTS(RP)) u_dut12 (
        .clk(clk), .reset(reset), .write_in(write_in), .write_addr_in(write_addr_in),
        .write_data_in(write_data_in), .write_be_in(write_be_in), .read_in(read_in),
        .read_addr_in(read_addr_in), .read_data_out(rd_b), .read_valid_out(rv_b),
        .clear_in(clear_in), .busy_out(busy_b), .debugen_in(debugen_in)
    );

    int          depth [2] = '{16, 12};
    logic [DW-1:0] mdl [2][16];
    int          busy_cnt [2];
    logic [DW-1:0] exp_rd [2][RP];
    logic        exp_rv [2];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < DW/8; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = depth[i];
            exp_rv[i] = 1'b0;
            for (int p = 0; p < RP; p++) exp_rd[i][p] = '0;
        end
    endtask

    // A sweep is observably equivalent to zeroing everything once it finishes.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (busy_cnt[i] > 0) begin
                busy_cnt[i]--;
                exp_rv[i] = 1'b0;
                if (busy_cnt[i] == 0) for (int a = 0; a < 16; a++) mdl[i][a] = '0;
            end else begin
                int wa;
                wa = int'(write_addr_in);
                exp_rv[i] = read_in;
                if (read_in) begin
                    for (int p = 0; p < RP; p++) begin
                        int ra;
                        logic [DW-1:0] v;
                        ra = int'(read_addr_in[p*AW +: AW]);
                        v = '0;
                        if (ra < depth[i]) begin
                            v = mdl[i][ra];
                            if (write_in && wa == ra) v = merge(v, write_data_in, write_be_in);
                        end
                        exp_rd[i][p] = v;
                    end
                end
                if (write_in && wa < depth[i]) mdl[i][wa] = merge(mdl[i][wa], write_data_in, write_be_in);
                if (clear_in) busy_cnt[i] = depth[i];
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check_eq($sformatf("%s busy16", ph), 64'(busy_a), 64'(busy_cnt[0] > 0));
        check_eq($sformatf("%s busy12", ph), 64'(busy_b), 64'(busy_cnt[1] > 0));
        check_eq($sformatf("%s valid16", ph), 64'(rv_a), 64'(exp_rv[0]));
        check_eq($sformatf("%s valid12", ph), 64'(rv_b), 64'(exp_rv[1]));
        check_eq($sformatf("%s data16", ph), 64'(rd_a), {exp_rd[0][1], exp_rd[0][0]});
        check_eq($sformatf("%s data12", ph), 64'(rd_b), {exp_rd[1][1], exp_rd[1][0]});
    endtask

    task automatic step(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic idle_inputs();
        write_in = 1'b0; read_in = 1'b0; clear_in = 1'b0;
    endtask

    task automatic random_inputs(input int clear_odds);
        write_in      = $urandom_range(0, 1) == 1;
        read_in       = $urandom_range(0, 1) == 1;
        clear_in      = (clear_odds > 0) && ($urandom_range(0, clear_odds - 1) == 0);
        write_addr_in = AW'($urandom_range(0, 15));
        write_data_in = $urandom;
        write_be_in   = 4'($urandom_range(0, 15));
        read_addr_in  = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
        debugen_in    = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("in_reset");
        #3 reset = 1'b1;
        n = 0;
        while (busy_a && n < 40) begin step("sweep0"); n++; end
        check_eq("reset_busy_len16", 64'(n), 64'd16);

        read_in = 1'b1;
        for (int a = 0; a < 16; a++) begin
            read_addr_in = {AW'(15 - a), AW'(a)};
            step("zero_read");
            check_eq("zero_read_p0", 64'(rd_a[31:0]), 64'd0);
        end
        idle_inputs();

        write_in = 1'b1; write_addr_in = 4'd3; write_data_in = 32'hDEADBEEF; write_be_in = 4'hF;
        step("be_wr1");
        write_data_in = 32'h11223344; write_be_in = 4'h5;
        step("be_wr2");
        write_in = 1'b0; read_in = 1'b1; read_addr_in = {4'd3, 4'd3};
        step("be_rd");
        check_eq("be_merge", 64'(rd_a[31:0]), 64'hDE22BE44);

        write_in = 1'b1; write_addr_in = 4'd7; write_data_in = 32'hA5A5A5A5; write_be_in = 4'hF;
        read_addr_in = {4'd8, 4'd7};
        step("bypass");
        check_eq("bypass_p0", 64'(rd_a[31:0]), 64'hA5A5A5A5);
        check_eq("bypass_p0_d12", 64'(rd_b[31:0]), 64'hA5A5A5A5);

        write_addr_in = 4'd14; write_data_in = 32'h12345678; read_addr_in = {4'd14, 4'd14};
        step("oob");
        check_eq("oob_read_d12", 64'(rd_b), 64'd0);
        write_in = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read_addr_in = {AW'(a), AW'(a)};
            step("oob_scan");
        end

        for (int c = 0; c < 60; c++) begin random_inputs(0); step("fill"); end
        idle_inputs();
        clear_in = 1'b1;
        step("clear_req");
        clear_in = 1'b0;
        n = 0;
        while (busy_b && n < 40) begin
            random_inputs(0); clear_in = 1'b0;
            step("clearing");
            n++;
        end
        check_eq("clear_busy_len12", 64'(n), 64'd12);
        idle_inputs();
        while (busy_a && n < 40) begin step("clearing16"); n++; end
        read_in = 1'b1;
        for (int a = 0; a < 16; a++) begin
            read_addr_in = {AW'(a), AW'(a)};
            step("post_clear");
        end

        idle_inputs();
        clear_in = 1'b1;
        step("clear_req2");
        clear_in = 1'b0;
        repeat (5) step("part_sweep");
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("mid_reset");
        write_in = 1'b1; read_in = 1'b1;
        @(posedge clk);
        #1;
        compare_all("mid_reset_edge");
        idle_inputs();
        #3 reset = 1'b1;
        n = 0;
        while (busy_a && n < 40) begin step("sweep1"); n++; end
        check_eq("rereset_busy_len16", 64'(n), 64'd16);

        for (int c = 0; c < 400; c++) begin random_inputs(40); step("rand"); end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
